// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: per-channel square wave and tick enable,
// divisor updates applied glitch-free at period boundaries. Optional macro: CLKDIV_ALIGN_EN.
module clk_div_multi #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = 2,
  localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
`ifdef CLKDIV_ALIGN_EN
  input  logic              align,
`endif
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] clkout,
  output logic [NUM_CH-1:0] tick
);

  logic [DIV_W-1:0]  r_cnt  [NUM_CH];
  logic [DIV_W-1:0]  r_div  [NUM_CH];
  logic [DIV_W-1:0]  r_pend [NUM_CH];
  logic [NUM_CH-1:0] r_busy;
  logic [NUM_CH-1:0] r_clkout;
  logic [NUM_CH-1:0] r_tick;
  logic              r_restart;

  logic [DIV_W-1:0]  w_cnt_nx  [NUM_CH];
  logic [DIV_W-1:0]  w_div_nx  [NUM_CH];
  logic [DIV_W-1:0]  w_pend_nx [NUM_CH];
  logic [DIV_W:0]    w_half    [NUM_CH];
  logic [NUM_CH-1:0] w_busy_nx;
  logic [NUM_CH-1:0] w_clk_nx;
  logic [NUM_CH-1:0] w_tick_nx;
  logic [NUM_CH-1:0] w_xfer;
  logic [NUM_CH-1:0] w_at_end;
  logic [NUM_CH-1:0] w_apply;
  logic              w_in_range;
  logic              w_restart;

  assign w_in_range = 32'(cfg_ch) < NUM_CH;
  assign cfg_ready  = w_in_range ? ~r_busy[cfg_ch] : 1'b1;

  // r_restart marks the first edge after reset so that edge lands on cnt=0 like an align.
`ifdef CLKDIV_ALIGN_EN
  assign w_restart = r_restart | align;
`else
  assign w_restart = r_restart;
`endif

  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      w_xfer[c]    = cfg_valid && cfg_ready && w_in_range && (cfg_ch == CH_W'(c));
      w_at_end[c]  = (r_div[c] < DIV_W'(2)) || (r_cnt[c] == r_div[c] - DIV_W'(1));
      w_apply[c]   = r_busy[c] && (w_restart || w_at_end[c]);
      w_div_nx[c]  = w_apply[c] ? r_pend[c] : r_div[c];
      w_cnt_nx[c]  = (w_restart || w_at_end[c]) ? '0 : r_cnt[c] + DIV_W'(1);
      w_pend_nx[c] = w_xfer[c] ? cfg_div : r_pend[c];
      w_busy_nx[c] = w_xfer[c] | (r_busy[c] & ~w_apply[c]);
      w_half[c]    = ({1'b0, w_div_nx[c]} + (DIV_W+1)'(1)) >> 1;
      w_clk_nx[c]  = {1'b0, w_cnt_nx[c]} < w_half[c];
      w_tick_nx[c] = (w_div_nx[c] != '0) && (w_cnt_nx[c] == w_div_nx[c] - DIV_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        r_cnt[c]  <= '0;
        r_div[c]  <= DIV_W'(DEFAULT_DIV);
        r_pend[c] <= '0;
      end
      r_busy    <= '0;
      r_clkout  <= '0;
      r_tick    <= '0;
      r_restart <= 1'b1;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        r_cnt[c]  <= w_cnt_nx[c];
        r_div[c]  <= w_div_nx[c];
        r_pend[c] <= w_pend_nx[c];
      end
      r_busy    <= w_busy_nx;
      r_clkout  <= w_clk_nx;
      r_tick    <= w_tick_nx;
      r_restart <= 1'b0;
    end
  end

  assign busy   = r_busy;
  assign clkout = r_clkout;
  assign tick   = r_tick;

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: cycle vector table on a 4-channel instance, plus
// hand sequences for a narrow 3-channel instance and the optional align restart.
module tb_clk_div_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic [1:0]  cfg_ch = '0;
  logic [15:0] cfg_div = '0;
  logic        cfg_ready;
  logic [3:0]  busy, clkout, tick;
`ifdef CLKDIV_ALIGN_EN
  logic        align = 1'b0;
  logic        align2 = 1'b0;
`endif

  logic        rst2 = 1'b1;
  logic        v2 = 1'b0;
  logic [1:0]  ch2 = '0;
  logic [3:0]  div2 = '0;
  logic        ready2;
  logic [2:0]  busy2, clk2o, tick2;

  clk_div_multi #(.NUM_CH(4), .DIV_W(16), .DEFAULT_DIV(2)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div),
`ifdef CLKDIV_ALIGN_EN
    .align(align),
`endif
    .busy(busy), .clkout(clkout), .tick(tick));

  clk_div_multi #(.NUM_CH(3), .DIV_W(4), .DEFAULT_DIV(3)) dut2 (
    .clk(clk), .rst(rst2), .cfg_valid(v2), .cfg_ready(ready2),
    .cfg_ch(ch2), .cfg_div(div2),
`ifdef CLKDIV_ALIGN_EN
    .align(align2),
`endif
    .busy(busy2), .clkout(clk2o), .tick(tick2));

  typedef struct {
    logic        rst;
    logic        v;
    logic [1:0]  ch;
    logic [15:0] div;
    logic        rdy;
    logic [3:0]  clk;
    logic [3:0]  tk;
    logic [3:0]  bsy;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic v, input logic [1:0] ch,
                              input logic [15:0] d, input logic rdy,
                              input logic [3:0] c, input logic [3:0] t, input logic [3:0] b);
    vec_t x;
    x.rst = r; x.v = v; x.ch = ch; x.div = d; x.rdy = rdy; x.clk = c; x.tk = t; x.bsy = b;
    return x;
  endfunction

  task automatic run1(input vec_t t, input int idx);
    rst = t.rst; cfg_valid = t.v; cfg_ch = t.ch; cfg_div = t.div;
    #1 check($sformatf("v%0d ready", idx), {31'd0, cfg_ready}, {31'd0, t.rdy});
    @(posedge clk); #1;
    check($sformatf("v%0d clkout", idx), {28'd0, clkout}, {28'd0, t.clk});
    check($sformatf("v%0d tick", idx),   {28'd0, tick},   {28'd0, t.tk});
    check($sformatf("v%0d busy", idx),   {28'd0, busy},   {28'd0, t.bsy});
  endtask

  task automatic drive1(input logic v, input logic [1:0] ch, input logic [15:0] d);
    cfg_valid = v; cfg_ch = ch; cfg_div = d;
    @(posedge clk); #1;
  endtask

  task automatic step2(input logic r, input logic v, input logic [1:0] ch, input logic [3:0] d);
    rst2 = r; v2 = v; ch2 = ch; div2 = d;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //          rst v  ch  div rdy clk   tick  busy
    vecs.push_back(mk(1, 0, 0, 0, 1, 4'h0, 4'h0, 4'h0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 4'h0, 4'h0, 4'h0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'hF, 4'h0, 4'h0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'h0, 4'hF, 4'h0));
    vecs.push_back(mk(0, 1, 1, 5, 1, 4'hF, 4'h0, 4'h2));
    vecs.push_back(mk(0, 1, 1, 7, 0, 4'h0, 4'hF, 4'h2));
    vecs.push_back(mk(0, 1, 2, 3, 1, 4'hF, 4'h0, 4'h4));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'h2, 4'hD, 4'h4));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'hF, 4'h0, 4'h0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'h4, 4'h9, 4'h0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'h9, 4'h6, 4'h0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'h6, 4'h9, 4'h0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 4'hF, 4'h0, 4'h1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 4'h2, 4'hD, 4'h1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 4'hC, 4'h0, 4'h0));
    vecs.push_back(mk(0, 1, 0, 3, 1, 4'h4, 4'hA, 4'h1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 4'hB, 4'h4, 4'h0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'h7, 4'h8, 4'h0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'hE, 4'h1, 4'h0));
    vecs.push_back(mk(0, 1, 3, 1, 1, 4'h1, 4'hC, 4'h8));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'hD, 4'hA, 4'h0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'hE, 4'h9, 4'h0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'hB, 4'hC, 4'h0));
    vecs.push_back(mk(1, 1, 1, 9, 1, 4'h0, 4'h0, 4'h0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'hF, 4'h0, 4'h0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'h0, 4'hF, 4'h0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'hF, 4'h0, 4'h0));

    for (int i = 0; i < vecs.size(); i++) run1(vecs[i], i);

    // Narrow instance: out-of-range channel dropped, then max divisor 15 on ch0.
    step2(1, 0, 0, 0);
    check("n reset clk", {29'd0, clk2o}, 32'd0);
    check("n reset busy", {29'd0, busy2}, 32'd0);
    rst2 = 1'b0; v2 = 1'b1; ch2 = 2'd3; div2 = 4'd5;
    #1 check("n bad-ch ready", {31'd0, ready2}, 32'd1);
    @(posedge clk); #1;
    check("n e1 clk", {29'd0, clk2o}, 32'h7);
    check("n e1 busy", {29'd0, busy2}, 32'h0);
    v2 = 1'b1; ch2 = 2'd0; div2 = 4'd15;
    #1 check("n wr ready", {31'd0, ready2}, 32'd1);
    @(posedge clk); #1;
    check("n e2 clk", {29'd0, clk2o}, 32'h7);
    check("n e2 busy", {29'd0, busy2}, 32'h1);
    step2(0, 0, 0, 0);
    check("n e3 tick", {29'd0, tick2}, 32'h7);
    check("n e3 busy", {29'd0, busy2}, 32'h1);
    step2(0, 0, 0, 0);
    check("n e4 clk", {29'd0, clk2o}, 32'h7);
    check("n e4 tick", {29'd0, tick2}, 32'h0);
    check("n e4 busy", {29'd0, busy2}, 32'h0);
    for (int k = 1; k <= 15; k++) begin
      int c0, c12;
      logic [2:0] ec, et;
      step2(0, 0, 0, 0);
      c0 = k % 15;
      c12 = k % 3;
      ec = {c12 < 2, c12 < 2, c0 < 8};
      et = {c12 == 2, c12 == 2, c0 == 14};
      check($sformatf("n k%0d clk", k), {29'd0, clk2o}, {29'd0, ec});
      check($sformatf("n k%0d tick", k), {29'd0, tick2}, {29'd0, et});
    end

`ifdef CLKDIV_ALIGN_EN
    drive1(1, 0, 16'd4);
    drive1(1, 1, 16'd6);
    drive1(0, 0, 0);
    drive1(0, 0, 0);
    drive1(0, 0, 0);
    check("a pre busy", {28'd0, busy}, 32'h0);
    align = 1'b1; cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 16'd5;
    @(posedge clk); #1;
    align = 1'b0; cfg_valid = 1'b0;
    check("a edge clk", {28'd0, clkout}, 32'hF);
    check("a edge tick", {28'd0, tick}, 32'h0);
    check("a edge busy", {28'd0, busy}, 32'h4);
    for (int k = 1; k <= 6; k++) begin
      drive1(0, 0, 0);
      check($sformatf("a k%0d tick0", k), {31'd0, tick[0]}, {31'd0, k == 3});
      check($sformatf("a k%0d tick1", k), {31'd0, tick[1]}, {31'd0, k == 5});
      check($sformatf("a k%0d busy", k), {28'd0, busy}, (k == 1) ? 32'h4 : 32'h0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
